// File: rtl/phold_event_collector.sv
// Collects events from NCORE phold cores through a round-robin arbiter into a
// first-word-fall-through FIFO; one event per two cycles (grant, then ack).
`ifndef TW
`define TW 16
`endif

module phold_event_collector #(
  parameter int NCORE = 4,
  parameter int NCB   = 2,
  parameter int NIDB  = 3,
  parameter int LDB   = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCORE-1:0]       core_ready,
  input  logic [NCORE*`TW-1:0]   core_time,
  input  logic [NCORE*NIDB-1:0]  core_target,
  output logic [NCORE-1:0]       core_ack,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [`TW-1:0]         out_time,
  output logic [NIDB-1:0]        out_target,
  output logic [NCB-1:0]         out_src,
  output logic [LDB:0]           fifo_count,
  output logic [31:0]            evt_total
);

  localparam int DEPTH = 1 << LDB;
  localparam logic [LDB:0] FULL = (LDB+1)'(DEPTH);

  typedef enum logic {ARB, ACK} state_t;

  typedef struct packed {
    logic [`TW-1:0]  t;
    logic [NIDB-1:0] g;
    logic [NCB-1:0]  s;
  } evt_t;

  state_t           state_q, state_d;
  logic [NCORE-1:0] ack_q, ack_d;
  logic [NCB-1:0]   last_q, last_d;
  logic [LDB-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LDB:0]     cnt_q, cnt_d;
  logic [31:0]      evt_q, evt_d;

  logic             grant, push, pop;
  logic [NCB-1:0]   gidx;
  evt_t             new_evt;
  evt_t             mem [DEPTH];

  // Search starts one past the last granted core so every core gets a turn.
  always_comb begin
    grant = 1'b0;
    gidx  = '0;
    for (int k = 1; k <= NCORE; k++) begin
      if (!grant && core_ready[(int'(last_q) + k) % NCORE]) begin
        grant = 1'b1;
        gidx  = NCB'((int'(last_q) + k) % NCORE);
      end
    end
  end

  always_comb begin
    new_evt.t = core_time[int'(gidx)*`TW +: `TW];
    new_evt.g = core_target[int'(gidx)*NIDB +: NIDB];
    new_evt.s = gidx;
  end

  always_comb begin
    state_d = state_q;
    ack_d   = '0;
    last_d  = last_q;
    evt_d   = evt_q;
    push    = 1'b0;
    case (state_q)
      ARB: begin
        // Full check uses the registered count; a same-cycle pop does not help.
        if (grant && cnt_q != FULL) begin
          push        = 1'b1;
          ack_d[gidx] = 1'b1;
          last_d      = gidx;
          evt_d       = evt_q + 32'd1;
          state_d     = ACK;
        end
      end
      ACK:     state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  always_comb begin
    pop    = (cnt_q != '0) && out_ready;
    wptr_d = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop  ? rptr_q + 1'b1 : rptr_q;
    cnt_d  = cnt_q + (LDB+1)'(push) - (LDB+1)'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB;
      ack_q   <= '0;
      last_q  <= NCB'(NCORE-1);
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      evt_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      last_q  <= last_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      evt_q   <= evt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= new_evt;
  end

  assign core_ack   = ack_q;
  assign out_valid  = (cnt_q != '0);
  assign out_time   = mem[rptr_q].t;
  assign out_target = mem[rptr_q].g;
  assign out_src    = mem[rptr_q].s;
  assign fifo_count = cnt_q;
  assign evt_total  = evt_q;

endmodule

// File: tb/tb_phold_event_collector.sv
// Randomized bench for phold_event_collector against a queue-based event model.
`ifndef TW
`define TW 16
`endif

module tb_phold_event_collector;
  localparam int NCORE = 4, NCB = 2, NIDB = 3, LDB = 3;
  localparam int DEPTH = 1 << LDB;

  logic                  clk = 0, rst = 1;
  logic [NCORE-1:0]      core_ready;
  logic [NCORE*`TW-1:0]  core_time;
  logic [NCORE*NIDB-1:0] core_target;
  logic [NCORE-1:0]      core_ack;
  logic                  out_valid, out_ready;
  logic [`TW-1:0]        out_time;
  logic [NIDB-1:0]       out_target;
  logic [NCB-1:0]        out_src;
  logic [LDB:0]          fifo_count;
  logic [31:0]           evt_total;

  phold_event_collector #(.NCORE(NCORE), .NCB(NCB), .NIDB(NIDB), .LDB(LDB)) dut (
    .clk(clk), .rst(rst), .core_ready(core_ready), .core_time(core_time),
    .core_target(core_target), .core_ack(core_ack), .out_valid(out_valid),
    .out_ready(out_ready), .out_time(out_time), .out_target(out_target),
    .out_src(out_src), .fifo_count(fifo_count), .evt_total(evt_total));

  always #5 clk = ~clk;

  // core side stimulus
  logic [NCORE-1:0] rdy;
  logic [`TW-1:0]   tm [NCORE];
  logic [NIDB-1:0]  tg [NCORE];
  always_comb begin
    core_ready = rdy;
    for (int i = 0; i < NCORE; i++) begin
      core_time[i*`TW +: `TW]   = tm[i];
      core_target[i*NIDB +: NIDB] = tg[i];
    end
  end

  // reference model: FIFO contents as a queue, plus ack/priority bookkeeping
  typedef struct { logic [`TW-1:0] t; logic [NIDB-1:0] g; int s; } ev_t;
  ev_t q[$];
  bit  m_ack;
  int  m_ack_idx, m_last;
  logic [31:0] m_evt;

  int req_pct, ord_pct;
  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic void model_reset();
    q.delete();
    m_ack = 0; m_ack_idx = 0; m_last = NCORE - 1; m_evt = 0;
  endfunction

  // advance the model across the coming rising edge using the driven inputs
  function automatic void model_edge();
    bit pop, gr;
    int gi;
    pop = (q.size() != 0) && out_ready;
    gr = 0; gi = 0;
    if (!m_ack && q.size() < DEPTH)
      for (int k = 1; k <= NCORE; k++)
        if (!gr && rdy[(m_last + k) % NCORE]) begin gr = 1; gi = (m_last + k) % NCORE; end
    if (pop) void'(q.pop_front());
    if (gr) begin
      q.push_back('{t: tm[gi], g: tg[gi], s: gi});
      m_last = gi;
      m_evt++;
    end
    m_ack = gr; m_ack_idx = gi;
  endfunction

  task automatic check_outputs();
    chk("core_ack", core_ack, m_ack ? (64'd1 << m_ack_idx) : 64'd0);
    chk("fifo_count", fifo_count, q.size());
    chk("out_valid", out_valid, q.size() != 0);
    chk("evt_total", evt_total, m_evt);
    if (q.size() != 0) begin
      chk("out_time", out_time, q[0].t);
      chk("out_target", out_target, q[0].g);
      chk("out_src", out_src, q[0].s);
    end
  endtask

  task automatic drive(input int inj = -1, input logic [`TW-1:0] it = 0,
                       input logic [NIDB-1:0] ig = 0);
    for (int i = 0; i < NCORE; i++) begin
      if (m_ack && m_ack_idx == i) rdy[i] = 1'b0;
      else if (!rdy[i] && $urandom_range(99) < req_pct) begin
        rdy[i] = 1'b1; tm[i] = `TW'($urandom); tg[i] = NIDB'($urandom);
      end
    end
    if (inj >= 0) begin rdy[inj] = 1'b1; tm[inj] = it; tg[inj] = ig; end
    out_ready = ($urandom_range(99) < ord_pct);
    model_edge();
  endtask

  task automatic step(input int inj = -1, input logic [`TW-1:0] it = 0,
                      input logic [NIDB-1:0] ig = 0);
    @(negedge clk);
    check_outputs();
    drive(inj, it, ig);
  endtask

  initial begin
    int guard;
    rdy = '0; out_ready = 0; req_pct = 0; ord_pct = 0;
    for (int i = 0; i < NCORE; i++) begin tm[i] = '0; tg[i] = '0; end
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_ack", core_ack, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_evt", evt_total, 0);
    rst = 0;
    drive();

    // single event from core 2
    step(2, 16'h64, 3'd5);
    repeat (4) step();
    chk("single_count", fifo_count, 1);
    chk("single_time", out_time, 16'h64);
    chk("single_tgt", out_target, 5);
    chk("single_src", out_src, 2);
    chk("single_evt", evt_total, 1);

    // all cores busy with downstream always ready: round-robin order
    ord_pct = 100; req_pct = 100;
    repeat (40) step();

    // full FIFO, then exactly one pop frees one slot
    ord_pct = 0;
    repeat (30) step();
    chk("full_count", fifo_count, DEPTH);
    ord_pct = 100; step();
    ord_pct = 0;
    repeat (8) step();
    chk("refill_count", fifo_count, DEPTH);

    // mixed random traffic
    req_pct = 30; ord_pct = 50;
    repeat (1500) step();

    // asynchronous reset during ACK
    req_pct = 60; ord_pct = 20;
    guard = 0;
    while (!m_ack && guard < 50) begin step(); guard++; end
    chk("found_ack", m_ack, 1);
    @(posedge clk); #2;
    chk("pre_rst_ack", core_ack, 64'd1 << m_ack_idx);
    rst = 1; #1;
    chk("async_ack", core_ack, 0);
    chk("async_valid", out_valid, 0);
    chk("async_count", fifo_count, 0);
    model_reset();
    @(negedge clk);
    rdy = 4'b1010; req_pct = 0; ord_pct = 0;
    rst = 0;
    drive();
    step();
    chk("rst_first_grant", core_ack, 4'b0010);

    req_pct = 40; ord_pct = 60;
    repeat (300) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
